alu_ctrl_seq: RTL
=================

Name: alu_ctrl_seq

Overview:
Hardwired control sequencer that sits directly upstream of data_path and drives its control inputs.
- Replaces hand-driven control-signal waveforms with a clocked T-step state machine.
- Fetches an instruction through PC/MAR/MDR/IR, then executes register-register and unary ALU instructions, including MUL/DIV writes to HI/LO.
- Reads the IR value back from data_path and produces the 5-bit ALU op, bus-out selects and register-in strobes.

Parameters:
OP_W, 5, width of opcode field and ALU op output
NREG, 16, number of general registers; width of one-hot Rout/Rin vectors

Ports:
Clock  in  1  system clock; all state changes on rising edge
clear  in  1  reset, asynchronous, active-high
run  in  1  level; 1 = fetch/execute, 0 = park in IDLE at next instruction boundary
IR  in  32  instruction register contents from data_path; [31:27] opcode, [26:23] Ra (dest), [22:19] Rb, [18:15] Rc
op  out  OP_W  ALU operation code to data_path
PCout, MDRout, Zhighout, Zlowout  out  1 each  bus source selects
MARin, InPC, Read, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, Loin  out  1 each  register load / memory strobes
Rout  out  NREG  one-hot register bus-out select; bit i drives Ri out
Rin  out  NREG  one-hot register load; bit i drives Ri in
instr_done  out  1  one-cycle pulse in final step of each instruction
halted  out  1  sticky; set on HALT (and illegal opcode when trap is enabled)

Behaviour:
- Reset: async clear forces state IDLE and drives every output to 0 (op=0, Rout=Rin=0, halted=0, instr_done=0) immediately, including mid-instruction. No partial step completes.
- Output timing: controls are a combinational decode of the current state and IR. They are stable for the whole cycle and data_path captures at the next rising edge. At most one bus source is active per state.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED.
- IDLE: all 0; if run=1 go to T0, else stay.
- T0: PCout, MARin, InPC -> T1.
- T1: Read, MDRin -> T2.
- T2: MDRout, IRin -> T3. IR is decoded from T3 onward.
- Binary ops (ADD 00000, SUB 00001, AND 00010, OR 00011, SHL 00100, SHR 00101, SHRA 00110, ROL 00111, ROR 01000):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], op=opcode, ZHighin, Zlowin.
  - T5: Zlowout, Rin[Ra], instr_done.
- MUL 01001 / DIV 01010:
  - T3 and T4 as for binary ops.
  - T5: Zlowout, Loin.
  - T6: Zhighout, HIin, instr_done.
- Unary ops (NEG 01011, NOT 01100):
  - T3: Rout[Rb], op=opcode, ZHighin, Zlowin.
  - T4: Zlowout, Rin[Ra], instr_done.
- NOP 11010: T3 asserts instr_done only.
- HALT 11011: T3 asserts instr_done, next state HALTED.
- HALTED: halted=1, all other outputs 0; left only by clear.
- After the instr_done step: go to T0 if run=1, else IDLE. run is sampled only at instruction boundaries; dropping run mid-instruction does not abort it.
- op is 0 in every state except the ALU-strobe step.
- Register aliasing (Ra=Rb=Rc) is legal. Sequencing is unchanged and the dest is written only in the final step.
- Register index fields are 4 bits. Only indices below NREG are asserted; a higher index yields an all-zero one-hot vector.

Optional Feature:
ILL_OP_TRAP_EN
- Defined: any opcode not listed above, at T3, asserts instr_done, sets halted and enters HALTED.
- Undefined: unlisted opcodes behave exactly as NOP and execution continues with the next fetch.

Test Plan:
- Reset mid-T4: assert clear during T4 -> all outputs 0 within the same cycle; state IDLE; halted=0; no Rin pulse.
- run=1, IR=SHL R1,R2,R3 (opcode 00100, Ra=1, Rb=2, Rc=3) -> steps as follows, with instr_done in T5, then T0 again:
  - T0: PCout/MARin/InPC.
  - T1: Read/MDRin.
  - T2: MDRout/IRin.
  - T3: Rout=0x0004, Yin.
  - T4: Rout=0x0008, op=00100, ZHighin/Zlowin.
  - T5: Zlowout, Rin=0x0002.
- IR=MUL Ra=0, Rb=4, Rc=5 -> T5 Zlowout+Loin, T6 Zhighout+HIin; Rin stays 0x0000 throughout; total of 7 cycles from T0.
- IR=NOT R7,R6 -> T3: Rout=0x0040, op=01100; T4: Rin=0x0080 + instr_done; 5 cycles total.
- run dropped during T4 of an ADD -> instruction completes at T5, then IDLE; raising run again starts T0 next cycle.
- IR=HALT -> halted=1 after T3 and stays 1 with run=1; IR=11111 -> HALTED if ILL_OP_TRAP_EN is defined, else treated as NOP and the next fetch begins.

Source files
------------

// File: rtl/alu_ctrl_seq_if.sv
// Control bundle between alu_ctrl_seq (master) and data_path (slave): run/IR in, strobes out.
interface alu_ctrl_seq_if #(
  parameter int unsigned OP_W = 5,
  parameter int unsigned NREG = 16
);
  logic            run;
  logic [31:0]     IR;
  logic [OP_W-1:0] op;
  logic            PCout, MDRout, Zhighout, Zlowout;
  logic            MARin, InPC, Read, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, Loin;
  logic [NREG-1:0] Rout, Rin;
  logic            instr_done, halted;

  modport master (
    input  run, IR,
    output op, PCout, MDRout, Zhighout, Zlowout,
    output MARin, InPC, Read, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, Loin,
    output Rout, Rin, instr_done, halted
  );

  modport slave (
    output run, IR,
    input  op, PCout, MDRout, Zhighout, Zlowout,
    input  MARin, InPC, Read, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, Loin,
    input  Rout, Rin, instr_done, halted
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Hardwired T-step control sequencer for data_path: fetch, then ALU/MUL/DIV/unary execute.
// Define ILL_OP_TRAP_EN to halt on unlisted opcodes instead of treating them as NOP.
module alu_ctrl_seq #(
  parameter int unsigned OP_W = 5,
  parameter int unsigned NREG = 16
) (
  input logic           Clock,
  input logic           clear,
  alu_ctrl_seq_if.master bus
);

`ifdef ILL_OP_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam logic [4:0] OpMul  = 5'b01001;
  localparam logic [4:0] OpDiv  = 5'b01010;
  localparam logic [4:0] OpNeg  = 5'b01011;
  localparam logic [4:0] OpNot  = 5'b01100;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalted
  } state_e;

  state_e state_q, state_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_two_src, is_muldiv, is_unary, is_nop, is_halt, is_illegal;
  logic [NREG-1:0] ra_oh, rb_oh, rc_oh;
  logic       unused_ir;

  assign opcode    = bus.IR[31:27];
  assign ra        = bus.IR[26:23];
  assign rb        = bus.IR[22:19];
  assign rc        = bus.IR[18:15];
  assign unused_ir = ^bus.IR[14:0];

  assign is_muldiv  = (opcode == OpMul) || (opcode == OpDiv);
  assign is_two_src = (opcode <= 5'd8) || is_muldiv;
  assign is_unary   = (opcode == OpNeg) || (opcode == OpNot);
  assign is_nop     = (opcode == OpNop);
  assign is_halt    = (opcode == OpHalt);
  assign is_illegal = !(is_two_src || is_unary || is_nop || is_halt);

  // Indices at or above NREG select nothing.
  function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (32'(idx) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign ra_oh = onehot(ra);
  assign rb_oh = onehot(rb);
  assign rc_oh = onehot(rc);

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_e boundary;
    boundary = bus.run ? StT0 : StIdle;
    state_d  = state_q;
    unique case (state_q)
      StIdle:   state_d = bus.run ? StT0 : StIdle;
      StT0:     state_d = StT1;
      StT1:     state_d = StT2;
      StT2:     state_d = StT3;
      StT3: begin
        if (is_two_src || is_unary)                  state_d = StT4;
        else if (is_halt || (TrapEn && is_illegal))  state_d = StHalted;
        else                                         state_d = boundary;
      end
      StT4:     state_d = is_two_src ? StT5 : boundary;
      StT5:     state_d = is_muldiv ? StT6 : boundary;
      StT6:     state_d = boundary;
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.op         = '0;
    bus.PCout      = 1'b0;
    bus.MDRout     = 1'b0;
    bus.Zhighout   = 1'b0;
    bus.Zlowout    = 1'b0;
    bus.MARin      = 1'b0;
    bus.InPC       = 1'b0;
    bus.Read       = 1'b0;
    bus.MDRin      = 1'b0;
    bus.IRin       = 1'b0;
    bus.Yin        = 1'b0;
    bus.ZHighin    = 1'b0;
    bus.Zlowin     = 1'b0;
    bus.HIin       = 1'b0;
    bus.Loin       = 1'b0;
    bus.Rout       = '0;
    bus.Rin        = '0;
    bus.instr_done = 1'b0;
    bus.halted     = 1'b0;
    unique case (state_q)
      StT0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.InPC  = 1'b1;
      end
      StT1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
      end
      StT2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      StT3: begin
        if (is_two_src) begin
          bus.Rout = rb_oh;
          bus.Yin  = 1'b1;
        end else if (is_unary) begin
          bus.Rout    = rb_oh;
          bus.op      = OP_W'(opcode);
          bus.ZHighin = 1'b1;
          bus.Zlowin  = 1'b1;
        end else begin
          bus.instr_done = 1'b1;
        end
      end
      StT4: begin
        if (is_two_src) begin
          bus.Rout    = rc_oh;
          bus.op      = OP_W'(opcode);
          bus.ZHighin = 1'b1;
          bus.Zlowin  = 1'b1;
        end else if (is_unary) begin
          bus.Zlowout    = 1'b1;
          bus.Rin        = ra_oh;
          bus.instr_done = 1'b1;
        end
      end
      StT5: begin
        bus.Zlowout = 1'b1;
        if (is_muldiv) begin
          bus.Loin = 1'b1;
        end else begin
          bus.Rin        = ra_oh;
          bus.instr_done = 1'b1;
        end
      end
      StT6: begin
        bus.Zhighout   = 1'b1;
        bus.HIin       = 1'b1;
        bus.instr_done = 1'b1;
      end
      StHalted: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule
